matmul_job_sequencer: RTL and testbench
=======================================

// Module: matmul_job_sequencer
// PURPOSE
//  Top-level job controller for the UART 3x3 matrix-multiply engine. Waits for a start command byte,
//  steers the next 9 received bytes into matrix memory A and the next 9 into B, pulses the multiplier,
//  snapshots its 9x16-bit result and serializes it as 18 bytes to the UART transmitter.
//  Sits between uart_rx/uart_tx, both matrix_memory instances and the Calculator, all on bclk.
// PARAMETERS
//  ELEMS     9      elements per matrix (row-major A00..A22)
//  DATA_W    8      element / UART byte width
//  RES_W     16     result element width; sent as 2 bytes, MSB first
//  MULT_LAT  2      bclk cycles from mult_start pulse to mult_result valid
//  CMD_START 8'hA5  IDLE byte that opens a job; all other IDLE bytes are ignored
// PORTS
//  bclk         in   1    clock (UART bit-rate clock)
//  rst          in   1    reset, asynchronous, active-high
//  rx_data      in   8    byte from uart_rx, valid while rx_valid=1
//  rx_valid     in   1    one-cycle strobe per received byte
//  tx_busy      in   1    uart_tx busy
//  mult_result  in   144  R00 at [15:0] .. R22 at [143:128]
//  a_we         out  1    write strobe, matrix memory A
//  b_we         out  1    write strobe, matrix memory B
//  wr_addr      out  4    element address 0..8 for a_we/b_we
//  wr_data      out  8    write data (registered rx_data)
//  mult_start   out  1    one-cycle start pulse to Calculator
//  tx_data      out  8    byte to uart_tx, stable from tx_start until tx_busy falls
//  tx_start     out  1    one-cycle transmit request
//  state        out  3    current state encoding (debug/LED)
//  job_done     out  1    one-cycle pulse after byte 18 has fully left uart_tx
//  rx_drop      out  1    sticky: byte arrived during COMPUTE/SEND; cleared on next CMD_START
// BEHAVIOUR
//  - Reset: all outputs 0, state=IDLE(3'd0), counters 0, result snapshot 0. Reset mid-job aborts with
//    no further writes or tx_start; job restarts only on a new CMD_START.
//  - States: IDLE=0, RECV_A=1, RECV_B=2, COMPUTE=3, SEND_BYTE=4, SEND_WAIT=5.
//  - IDLE: rx_valid && rx_data==CMD_START -> RECV_A, elem_cnt=0, rx_drop=0.
//  - RECV_A/RECV_B: each rx_valid registers a_we (b_we) = 1 for one cycle, wr_addr=elem_cnt,
//    wr_data=rx_data, elem_cnt++. Byte with elem_cnt==ELEMS-1 is written, elem_cnt wraps to 0
//    and state advances (A->B, B->COMPUTE). Write latency 1 cycle after rx_valid. Never a_we&&b_we.
//  - COMPUTE: entry cycle drives mult_start=1 for exactly one cycle; wait counter runs MULT_LAT
//    cycles, then mult_result is captured into a 144-bit snapshot, byte_idx=0 -> SEND_BYTE.
//  - SEND_BYTE: when tx_busy==0: tx_data=snapshot byte byte_idx, tx_start=1 (one cycle) -> SEND_WAIT.
//    Byte k: element k>>1; even k = [15:8], odd k = [7:0] (MSB first, R00..R22).
//  - SEND_WAIT: first cycle ignores tx_busy (uart_tx latency guard); thereafter on tx_busy==0:
//    byte_idx==17 -> job_done pulse, IDLE; else byte_idx++ -> SEND_BYTE.
//  - rx_valid in COMPUTE/SEND_*: byte dropped, rx_drop=1. Counters are 5-bit, never exceed 17.
//  - rx_valid coinciding with a state change: handled by the state it arrived in (ninth A byte goes
//    to A; next byte goes to B).
// STRUCTURE
//  - Shared package mm_pkg: state localparams, CMD_START, ELEMS, RES_W (shared with control_unit/top).
//  - One sub-module natural: mm_result_serializer (snapshot register, byte mux, SEND_BYTE/SEND_WAIT
//    handshake with tx_busy); the sequencer FSM owns receive steering and mult_start.
// TESTING
//  - Reset mid-RECV_B (after 4 B bytes) -> state=0, no a_we/b_we/tx_start until next 0xA5.
//  - 0x11, 0xA5, A=1..9, B=identity -> a_we at addr 0..8 with 1..9, b_we 0..8; 0x11 ignored;
//    one mult_start; tx 00 01 00 02 .. 00 09; one job_done.
//  - A=all 0xFF, B=all 0xFF -> each R=0x2FA03 truncated to RES_W; bytes match [15:8],[7:0] of capture.
//  - tx_busy held high 40 cycles after each tx_start -> exactly 18 tx_start, never while tx_busy=1.
//  - Extra rx byte during SEND -> rx_drop=1, transmitted stream unchanged; next 0xA5 clears rx_drop.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants and state encodings for the UART 3x3 matrix-multiply job path.
package mm_pkg;

  localparam int ELEMS = 9;
  localparam int RES_W = 16;
  localparam int BYTES = 2 * ELEMS;
  localparam int CNT_W = 5;
  localparam logic [7:0] CMD_START = 8'hA5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RECV_A    = 3'd1,
    RECV_B    = 3'd2,
    COMPUTE   = 3'd3,
    SEND_BYTE = 3'd4,
    SEND_WAIT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_BYTE,
    SER_WAIT
  } ser_state_t;

endpackage

// File: rtl/mm_result_serializer.sv
// Snapshots the 9x16-bit product and streams it MSB-first as 18 bytes to uart_tx,
// pacing each byte on tx_busy.
module mm_result_serializer
  import mm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   bclk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [ELEMS*RES_W-1:0] result,
  input  logic                   tx_busy,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  output logic [2:0]             phase,
  output logic                   fin
);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  ser_state_t             ser_q, ser_d;
  logic [ELEMS*RES_W-1:0] snap;
  logic [CNT_W-1:0]       byte_idx, idx_d;
  logic                   guard, guard_d;
  logic [DATA_W-1:0]      data_d;
  logic                   start_d;

  // Byte k is element k>>1; even k carries the upper half of the element.
  function automatic logic [DATA_W-1:0] byte_of(input logic [ELEMS*RES_W-1:0] s,
                                                input logic [CNT_W-1:0]       k);
    logic [RES_W-1:0] word;
    word = RES_W'(s >> (k[CNT_W-1:1] * RES_W));
    return k[0] ? word[DATA_W-1:0] : word[RES_W-1 -: DATA_W];
  endfunction

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      ser_q    <= SER_IDLE;
      snap     <= '0;
      byte_idx <= '0;
      guard    <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      ser_q    <= ser_d;
      byte_idx <= idx_d;
      guard    <= guard_d;
      tx_data  <= data_d;
      tx_start <= start_d;
      if (capture) snap <= result;
    end
  end

  // guard skips the first SER_WAIT cycle, before uart_tx has had a chance to raise busy
  always_comb begin
    ser_d   = ser_q;
    idx_d   = byte_idx;
    guard_d = guard;
    data_d  = tx_data;
    start_d = 1'b0;
    fin     = 1'b0;
    case (ser_q)
      SER_IDLE: begin
        if (capture) begin
          idx_d = '0;
          ser_d = SER_BYTE;
        end
      end
      SER_BYTE: begin
        if (!tx_busy) begin
          data_d  = byte_of(snap, byte_idx);
          start_d = 1'b1;
          guard_d = 1'b1;
          ser_d   = SER_WAIT;
        end
      end
      SER_WAIT: begin
        if (guard) begin
          guard_d = 1'b0;
        end else if (!tx_busy) begin
          if (byte_idx == LAST_BYTE) begin
            fin   = 1'b1;
            ser_d = SER_IDLE;
          end else begin
            idx_d = byte_idx + CNT_W'(1);
            ser_d = SER_BYTE;
          end
        end
      end
      default: ser_d = SER_IDLE;
    endcase
  end

  assign phase = (ser_q == SER_BYTE) ? SEND_BYTE :
                 (ser_q == SER_WAIT) ? SEND_WAIT : IDLE;

endmodule

// File: rtl/matmul_job_sequencer.sv
// Job controller: waits for the start byte, steers 9+9 bytes into matrix memories A/B,
// pulses the Calculator and hands its result to the serializer.
module matmul_job_sequencer
  import mm_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MULT_LAT = 2
) (
  input  logic                   bclk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_valid,
  input  logic                   tx_busy,
  input  logic [ELEMS*RES_W-1:0] mult_result,
  output logic                   a_we,
  output logic                   b_we,
  output logic [3:0]             wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   mult_start,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  output logic [2:0]             state,
  output logic                   job_done,
  output logic                   rx_drop
);

  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(ELEMS - 1);
  localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(MULT_LAT);

  // SEND_BYTE here stands for the whole transmit phase; the serializer reports the sub-state.
  state_t            cur_state, state_d;
  logic [CNT_W-1:0]  elem_cnt, elem_d;
  logic [CNT_W-1:0]  wait_cnt, wait_d;
  logic              drop_d, a_we_d, b_we_d, start_d, capture, ser_fin;
  logic [3:0]        addr_d;
  logic [DATA_W-1:0] data_d;
  logic [2:0]        ser_phase;

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      cur_state  <= IDLE;
      elem_cnt   <= '0;
      wait_cnt   <= '0;
      rx_drop    <= 1'b0;
      a_we       <= 1'b0;
      b_we       <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      mult_start <= 1'b0;
      job_done   <= 1'b0;
    end else begin
      cur_state  <= state_d;
      elem_cnt   <= elem_d;
      wait_cnt   <= wait_d;
      rx_drop    <= drop_d;
      a_we       <= a_we_d;
      b_we       <= b_we_d;
      wr_addr    <= addr_d;
      wr_data    <= data_d;
      mult_start <= start_d;
      job_done   <= ser_fin;
    end
  end

  always_comb begin
    state_d = cur_state;
    elem_d  = elem_cnt;
    wait_d  = wait_cnt;
    drop_d  = rx_drop;
    a_we_d  = 1'b0;
    b_we_d  = 1'b0;
    addr_d  = wr_addr;
    data_d  = wr_data;
    start_d = 1'b0;
    capture = 1'b0;
    case (cur_state)
      IDLE: begin
        if (rx_valid && rx_data == DATA_W'(CMD_START)) begin
          state_d = RECV_A;
          elem_d  = '0;
          drop_d  = 1'b0;
        end
      end
      RECV_A, RECV_B: begin
        if (rx_valid) begin
          a_we_d = (cur_state == RECV_A);
          b_we_d = (cur_state == RECV_B);
          addr_d = elem_cnt[3:0];
          data_d = rx_data;
          if (elem_cnt == LAST_ELEM) begin
            elem_d  = '0;
            wait_d  = '0;
            state_d = (cur_state == RECV_A) ? RECV_B : COMPUTE;
            start_d = (cur_state == RECV_B);
          end else begin
            elem_d = elem_cnt + CNT_W'(1);
          end
        end
      end
      COMPUTE: begin
        if (rx_valid) drop_d = 1'b1;
        if (wait_cnt == LAT_CNT) begin
          capture = 1'b1;
          wait_d  = '0;
          state_d = SEND_BYTE;
        end else begin
          wait_d = wait_cnt + CNT_W'(1);
        end
      end
      SEND_BYTE: begin
        if (rx_valid) drop_d = 1'b1;
        if (ser_fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mm_result_serializer #(.DATA_W(DATA_W)) u_ser (
    .bclk     (bclk),
    .rst      (rst),
    .capture  (capture),
    .result   (mult_result),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .phase    (ser_phase),
    .fin      (ser_fin)
  );

  assign state = (cur_state == SEND_BYTE) ? ser_phase : cur_state;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Directed bench for matmul_job_sequencer with small models of the memories, Calculator and uart_tx.
module tb_matmul_job_sequencer;

  localparam int MULT_LAT = 2;

  logic         bclk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         tx_busy = 1'b0;
  logic [143:0] mult_result = '0;
  logic         a_we, b_we, mult_start, tx_start, job_done, rx_drop;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data, tx_data;
  logic [2:0]   state;

  always #5 bclk = ~bclk;

  matmul_job_sequencer #(.DATA_W(8), .MULT_LAT(MULT_LAT)) dut (
    .bclk(bclk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .mult_result(mult_result), .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .mult_start(mult_start), .tx_data(tx_data), .tx_start(tx_start), .state(state),
    .job_done(job_done), .rx_drop(rx_drop)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] we;    // 0 none, 1 A, 2 B
    logic [3:0] addr;
    logic [2:0] st;
    logic       ms;
  } vec_t;

  vec_t vecs[$];

  int total = 0, bad = 0;
  int n_mult = 0, n_start = 0, n_done = 0, n_awe = 0, n_bwe = 0;
  int busy_err = 0, stable_err = 0, both_err = 0;
  int busy_len = 0, busy_left = 0, lat = 0;
  logic          armed = 1'b0;
  logic [7:0]    cur_byte = '0;
  logic [7:0]    txq[$];
  logic [8:0][7:0] mem_a = '0, mem_b = '0;
  logic [143:0]  pend = '0;

  function automatic logic [143:0] prod(input logic [8:0][7:0] a, input logic [8:0][7:0] b);
    logic [143:0] r;
    logic [31:0]  s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s = s + 32'(a[i*3+k]) * 32'(b[k*3+j]);
        r[(i*3+j)*16 +: 16] = s[15:0];
      end
    return r;
  endfunction

  // Memories, Calculator and uart_tx models, sampled mid-cycle
  always @(negedge bclk) begin
    if (!rst) begin
      if (a_we) begin n_awe++; if (wr_addr < 4'd9) mem_a[wr_addr] = wr_data; end
      if (b_we) begin n_bwe++; if (wr_addr < 4'd9) mem_b[wr_addr] = wr_data; end
      if (a_we && b_we) both_err++;
      if (job_done) begin n_done++; if (tx_busy) busy_err++; end
      if (mult_start) begin
        n_mult++;
        armed = 1'b1;
        lat = 0;
        pend = prod(mem_a, mem_b);
        mult_result = {9{16'hBAD0}};
      end else if (armed) begin
        lat++;
        if (lat == MULT_LAT) begin mult_result = pend; armed = 1'b0; end
      end
      if (tx_busy && tx_data !== cur_byte) stable_err++;
      if (tx_start) begin
        if (tx_busy) busy_err++;
        n_start++;
        txq.push_back(tx_data);
        cur_byte = tx_data;
        if (busy_len > 0) begin tx_busy = 1'b1; busy_left = busy_len; end
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] we, input logic [3:0] addr,
                      input logic [2:0] st, input logic ms);
    vec_t v;
    v.d = d; v.we = we; v.addr = addr; v.st = st; v.ms = ms;
    vecs.push_back(v);
  endtask

  task automatic push_job(input logic [8:0][7:0] a, input logic [8:0][7:0] b);
    for (int j = 0; j < 9; j++) push(a[j], 2'd1, 4'(j), (j == 8) ? 3'd2 : 3'd1, 1'b0);
    for (int j = 0; j < 9; j++) push(b[j], 2'd2, 4'(j), (j == 8) ? 3'd3 : 3'd2, j == 8);
  endtask

  // Bytes go in back-to-back, one per cycle, so state-change boundaries are exercised.
  task automatic apply_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge bclk);
      rx_data = vecs[i].d;
      rx_valid = 1'b1;
      @(posedge bclk); #1;
      check($sformatf("vec%0d ctl", i), {a_we, b_we, state, mult_start},
            {vecs[i].we == 2'd1, vecs[i].we == 2'd2, vecs[i].st, vecs[i].ms});
      if (vecs[i].we != 2'd0)
        check($sformatf("vec%0d addr/data", i), {wr_addr, wr_data}, {vecs[i].addr, vecs[i].d});
    end
    @(negedge bclk);
    rx_valid = 1'b0;
    vecs.delete();
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge bclk);
    rx_data = d;
    rx_valid = 1'b1;
    @(negedge bclk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_counts();
    n_mult = 0; n_start = 0; n_done = 0; n_awe = 0; n_bwe = 0;
    txq.delete();
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (n_done == 0 && c < budget) begin @(posedge bclk); #1; c++; end
    check("job_done within budget", n_done != 0, 1);
    repeat (3) @(posedge bclk);
    #1;
    check("job_done pulse count", n_done, 1);
    check("state idle after job", state, 0);
  endtask

  task automatic check_stream(input string name, input logic [17:0][7:0] eb);
    check({name, " tx count"}, txq.size(), 18);
    for (int k = 0; k < 18; k++)
      check($sformatf("%s byte%0d", name, k), (k < txq.size()) ? txq[k] : 8'hxx, eb[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0][7:0]  ma, mb;
    logic [17:0][7:0] eb;
    logic [143:0]     r;
    logic [15:0]      w;
    int               c;

    repeat (3) @(posedge bclk);
    #1;
    check("reset outputs", {a_we, b_we, wr_addr, wr_data, mult_start, tx_data, tx_start,
                            job_done, rx_drop}, 0);
    check("reset state", state, 0);
    @(negedge bclk) rst = 1'b0;

    // Job 1: stray byte, then A=1..9, B=identity, short busy
    for (int j = 0; j < 9; j++) begin
      ma[j] = 8'(j + 1);
      mb[j] = (j % 4 == 0) ? 8'd1 : 8'd0;
    end
    clear_counts();
    busy_len = 3;
    push(8'h11, 2'd0, 4'd0, 3'd0, 1'b0);
    push(8'hA5, 2'd0, 4'd0, 3'd1, 1'b0);
    push_job(ma, mb);
    apply_vecs();
    wait_done(2000);
    for (int k = 0; k < 18; k++) eb[k] = (k % 2 == 1) ? 8'(k / 2 + 1) : 8'h00;
    check_stream("job1", eb);
    check("job1 mult_start cycles", n_mult, 1);
    check("job1 a/b writes", {16'(n_awe), 16'(n_bwe)}, {16'd9, 16'd9});
    check("job1 rx_drop", rx_drop, 0);

    // Job 2: all 0xFF, long busy, extra byte during transmit
    ma = '1;
    mb = '1;
    clear_counts();
    busy_len = 40;
    push(8'hA5, 2'd0, 4'd0, 3'd1, 1'b0);
    push_job(ma, mb);
    apply_vecs();
    c = 0;
    while (state < 3'd4 && c < 50) begin @(posedge bclk); #1; c++; end
    check("job2 reached send", state >= 3'd4, 1);
    repeat (45) @(posedge bclk);
    send_byte(8'h5A);
    #1;
    check("job2 rx_drop set", rx_drop, 1);
    wait_done(3000);
    for (int k = 0; k < 18; k++) eb[k] = (k % 2 == 0) ? 8'hFA : 8'h03;
    check_stream("job2", eb);
    check("job2 tx_start count", n_start, 18);
    check("job2 a writes", n_awe, 9);
    check("job2 rx_drop sticky", rx_drop, 1);
    check("tx_start never while busy", busy_err, 0);
    check("tx_data stable while busy", stable_err, 0);

    // Next start clears rx_drop; then reset in the middle of RECV_B
    send_byte(8'hA5);
    #1;
    check("start clears rx_drop", {state, rx_drop}, {3'd1, 1'b0});
    for (int j = 0; j < 9; j++) send_byte(8'(j + 16));
    for (int j = 0; j < 4; j++) send_byte(8'(j + 32));
    #1;
    check("in RECV_B before reset", state, 2);
    @(negedge bclk);
    #2 rst = 1'b1;
    #1;
    check("async reset state", state, 0);
    check("async reset outputs", {a_we, b_we, mult_start, tx_start, job_done, rx_drop}, 0);
    @(negedge bclk) rst = 1'b0;
    clear_counts();
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (5) @(posedge bclk);
    #1;
    check("no activity after reset", n_awe + n_bwe + n_start + n_mult, 0);
    check("idle after reset", state, 0);

    // Job 3: restart after reset, no tx backpressure
    ma = {8'd5, 8'd4, 8'd0, 8'd0, 8'd1, 8'd3, 8'd1, 8'd0, 8'd2};
    mb = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    clear_counts();
    busy_len = 0;
    push(8'hA5, 2'd0, 4'd0, 3'd1, 1'b0);
    push_job(ma, mb);
    apply_vecs();
    wait_done(500);
    r = prod(ma, mb);
    check("job3 R00 hand value", r[15:0], 16'd9);
    for (int k = 0; k < 18; k++) begin
      w = r[(k / 2) * 16 +: 16];
      eb[k] = (k % 2 == 1) ? w[7:0] : w[15:8];
    end
    check_stream("job3", eb);
    check("never a_we and b_we together", both_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
